serial_subtractor: RTL and testbench

Parametrised, bit-serial two's-complement subtractor computing a − b − bin over WIDTH bits, one bit per clock, LSB first. It uses a registered borrow in place of a ripple chain, trading latency for area. Operands are captured on a start handshake, and the result is held until the next operation. It sits beside the combinational half/full subtractor cells as the area-optimised arithmetic option for wide operands.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and width helper for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor, d = a - b - bin with borrow out
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, clear      : begin an operation (when not busy), synchronous abort
//   a, b, bin         : operands and borrow-in, captured when start is accepted
//   busy, done        : processing bits, one-cycle result-valid pulse
//   diff, bout, zero  : held result, final borrow out, diff == 0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = clog2(WIDTH);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, shifted;
  // Only WIDTH-1 partial bits are kept; the final bit goes straight into diff.
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d, d_bit, b_next;

  full_subtractor_cell u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(b_next)
  );

  assign shifted = {d_bit, res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      br_d    = 1'b0;
      diff_d  = '0;
      bout_d  = 1'b0;
      zero_d  = 1'b0;
    end else if (start && state_q != ST_SHIFT) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
    end else if (state_q == ST_SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = b_next;
      res_d = shifted[WIDTH-1:1];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = ST_DONE;
        cnt_d   = cnt_q;
        diff_d  = shifted;
        bout_d  = b_next;
        zero_d  = ~|shifted;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random scoreboard checks for WIDTH 8, 2 and 64
module tb_serial_subtractor;
  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, bin_in = 1'b0;
  logic [63:0] a_in = '0, b_in = '0;
  int          sel = 0, checks = 0, errors = 0;
  exp_t        sb[$];
  exp_t        last_e;

  logic        busy8, done8, bout8, zero8, busy2, done2, bout2, zero2, busy64, done64, bout64, zero64;
  logic [7:0]  diff8;
  logic [1:0]  diff2;
  logic [63:0] diff64;
  logic        o_busy, o_done, o_bout, o_zero;
  logic [63:0] o_diff;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .clear(clear),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );
  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .clear(clear),
    .a(a_in[1:0]), .b(b_in[1:0]), .bin(bin_in),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .zero(zero2)
  );
  serial_subtractor #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .clear(clear),
    .a(a_in), .b(b_in), .bin(bin_in),
    .busy(busy64), .done(done64), .diff(diff64), .bout(bout64), .zero(zero64)
  );

  always_comb begin
    o_busy = (sel == 0) ? busy8 : (sel == 1) ? busy2 : busy64;
    o_done = (sel == 0) ? done8 : (sel == 1) ? done2 : done64;
    o_bout = (sel == 0) ? bout8 : (sel == 1) ? bout2 : bout64;
    o_zero = (sel == 0) ? zero8 : (sel == 1) ? zero2 : zero64;
    o_diff = (sel == 0) ? 64'(diff8) : (sel == 1) ? 64'(diff2) : diff64;
  end

  function automatic int wof(input int s);
    return (s == 0) ? 8 : (s == 1) ? 2 : 64;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int s, input logic [63:0] ia, input logic [63:0] ib, input logic ibin);
    int          w;
    logic [63:0] m;
    logic [64:0] full;
    exp_t        e;
    w      = wof(s);
    m      = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full   = {1'b0, ia & m} - {1'b0, ib & m} - 65'(ibin);
    e.diff = full[63:0] & m;
    e.bout = full[w];
    e.zero = (e.diff == 64'd0);
    sb.push_back(e);
  endtask

  // Called just after the accept edge; waits (bounded) for done and scores it.
  task automatic wait_done(input int s, input bit glitch);
    int   n, bc, w;
    exp_t e;
    n = 1;
    bc = 0;
    w = wof(s);
    while (!o_done && n < 200) begin
      if (o_busy) bc++;
      if (glitch) begin
        start = (n == 3);
        a_in  = ~a_in;
        b_in  = b_in + 64'd5;
      end
      step();
      n++;
    end
    if (glitch) start = 1'b0;
    chk("latency", 64'(n), 64'(w + 1));
    chk("busy_cycles", 64'(bc), 64'(w));
    chk("busy_at_done", 64'(o_busy), 64'd0);
    chk("sb_depth", 64'(sb.size()), 64'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("diff", o_diff, e.diff);
    chk("bout", 64'(o_bout), 64'(e.bout));
    chk("zero", 64'(o_zero), 64'(e.zero));
    last_e = e;
  endtask

  task automatic op(input int s, input logic [63:0] ia, input logic [63:0] ib, input logic ibin, input bit glitch);
    sel    = s;
    a_in   = ia;
    b_in   = ib;
    bin_in = ibin;
    start  = 1'b1;
    push_exp(s, ia, ib, ibin);
    step();
    start = 1'b0;
    wait_done(s, glitch);
    step();
    chk("done_pulse", 64'(o_done), 64'd0);
    chk("diff_hold", o_diff, last_e.diff);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_diff"}, o_diff, 64'd0);
    chk({tag, "_bout"}, 64'(o_bout), 64'd0);
    chk({tag, "_zero"}, 64'(o_zero), 64'd0);
  endtask

  initial begin
    repeat (3) step();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step();
    op(0, 64'h5A, 64'h3C, 1'b0, 1'b0);
    op(0, 64'h10, 64'h20, 1'b0, 1'b0);
    op(0, 64'h00, 64'h00, 1'b1, 1'b0);
    op(0, 64'h77, 64'h77, 1'b0, 1'b0);
    // Back-to-back: start held high through DONE.
    sel = 0; a_in = 64'hFF; b_in = 64'h01; bin_in = 1'b0; start = 1'b1;
    push_exp(0, 64'hFF, 64'h01, 1'b0);
    step();
    a_in = 64'h01; b_in = 64'hFF;
    wait_done(0, 1'b0);
    push_exp(0, 64'h01, 64'hFF, 1'b0);
    step();
    start = 1'b0;
    wait_done(0, 1'b0);
    step();
    // start re-pulsed during SHIFT with other operands must be ignored.
    op(0, 64'h5A, 64'h3C, 1'b0, 1'b1);
    // Asynchronous reset at busy cycle 4.
    a_in = 64'hC3; b_in = 64'h21; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("rst_mid_busy", 64'(o_busy), 64'd1);
    chk("rst_mid_hold", o_diff, 64'h1E);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    step();
    rst_n = 1'b1;
    step();
    op(0, 64'hC3, 64'h21, 1'b0, 1'b0);
    // Synchronous clear at busy cycle 4.
    a_in = 64'h10; b_in = 64'h20; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("clr_mid_hold", o_diff, 64'hA2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_zero_outputs("clear");
    // clear and start together: clear wins.
    a_in = 64'h33; b_in = 64'h11; start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    chk("clr_start_busy", 64'(o_busy), 64'd0);
    step();
    chk("clr_start_busy2", 64'(o_busy), 64'd0);
    op(0, 64'h10, 64'h20, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      op(1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    op(1, 64'h0, 64'h3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    op(2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
